// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the configurable UART
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int MIN_NBITS = 5;
  localparam int MAX_NBITS = 9;

  // Bound a requested data-bit count into [MIN_NBITS, max_n].
  function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input int unsigned max_n);
    if (n < 4'(MIN_NBITS)) return 4'(MIN_NBITS);
    if (32'(n) > max_n) return 4'(max_n);
    return n;
  endfunction

  // Encoding 3 is an alias for "no parity".
  function automatic parity_e decode_parity(input logic [1:0] p);
    case (p)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - small synchronous FIFO with level/full/empty status
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; empty/level guard against reading stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter with TX FIFO
`timescale 1ns/1ps
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [3:0]                    cfg_nbits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          uart_tx
);

  localparam int LW     = $clog2(FIFO_DEPTH) + 1;
  localparam int NB_CAP = (DATA_W < MAX_NBITS) ? DATA_W : MAX_NBITS;

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_s_q, div_s_d;
  logic [3:0]        nbits_s_q, nbits_s_d;
  parity_e           par_s_q, par_s_d;
  logic              stop2_s_q, stop2_s_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              acc_q, acc_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic              push, pop, start_frame, tick;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [LW-1:0]     level_nxt;

  assign s_ready = rst_n && !fifo_full;
  assign push    = s_valid && s_ready;
  assign uart_tx = tx_q;
  assign tx_busy = busy_q;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state, serial output and datapath updates for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_s_d     = div_s_q;
    nbits_s_d   = nbits_s_q;
    par_s_d     = par_s_q;
    stop2_s_d   = stop2_s_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    tx_d        = tx_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    tick        = (cnt_q == '0);

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          cnt_d     = div_s_q;
          tx_d      = sh_q[0];
          acc_d     = sh_q[0];
          sh_d      = sh_q >> 1;
          bit_cnt_d = nbits_s_q - 4'd1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = div_s_q;
          if (bit_cnt_q != 4'd0) begin
            tx_d      = sh_q[0];
            acc_d     = acc_q ^ sh_q[0];
            sh_d      = sh_q >> 1;
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else if (par_s_q != PAR_NONE) begin
            state_d = PARITY;
            tx_d    = (par_s_q == PAR_ODD) ? ~acc_q : acc_q;
          end else begin
            state_d   = STOP;
            tx_d      = 1'b1;
            bit_cnt_d = stop2_s_q ? 4'd1 : 4'd0;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      PARITY: begin
        if (tick) begin
          state_d   = STOP;
          cnt_d     = div_s_q;
          tx_d      = 1'b1;
          bit_cnt_d = stop2_s_q ? 4'd1 : 4'd0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (bit_cnt_q != 4'd0) begin
            cnt_d     = div_s_q;
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start snapshots the configuration so mid-frame changes are ignored.
    if (start_frame) begin
      pop       = 1'b1;
      sh_d      = fifo_rdata;
      div_s_d   = cfg_div;
      cnt_d     = cfg_div;
      nbits_s_d = clamp_nbits(cfg_nbits, NB_CAP);
      par_s_d   = decode_parity(cfg_parity);
      stop2_s_d = cfg_stop2;
      tx_d      = 1'b0;
      state_d   = START;
    end

    level_nxt = fifo_level;
    if (push && !pop)      level_nxt = fifo_level + LW'(1);
    else if (pop && !push) level_nxt = fifo_level - LW'(1);

    busy_d = (state_d != IDLE) || (level_nxt != '0);
  end

  // State and datapath registers; reset parks the line high in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_s_q   <= '0;
      nbits_s_q <= 4'(MIN_NBITS);
      par_s_q   <= PAR_NONE;
      stop2_s_q <= 1'b0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      acc_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_s_q   <= div_s_d;
      nbits_s_q <= nbits_s_d;
      par_s_q   <= par_s_d;
      stop2_s_q <= stop2_s_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [3:0]        cfg_nbits = 4'd8;
  logic [1:0]        cfg_parity = 2'd0;
  logic              cfg_stop2 = 1'b0;
  logic [LW-1:0]     fifo_level;
  logic              tx_busy;
  logic              uart_tx;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .cfg_div    (cfg_div),
    .cfg_nbits  (cfg_nbits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .fifo_level (fifo_level),
    .tx_busy    (tx_busy),
    .uart_tx    (uart_tx)
  );

  typedef struct {
    logic [8:0] data;
    int         nbits;
    int         par;
    bit         stop2;
    int         div;
    bit         no_gap;
  } frame_t;

  typedef struct {
    frame_t f;
    int     exp_busy;
  } vec_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic frame_t mk(input logic [8:0] d, input int nb, input int p,
                                input bit s2, input int dv, input bit ng);
    frame_t f;
    f.data = d; f.nbits = nb; f.par = p; f.stop2 = s2; f.div = dv; f.no_gap = ng;
    return f;
  endfunction

  function automatic int clampn(input int n);
    if (n < 5) return 5;
    if (n > 9) return 9;
    return n;
  endfunction

  function automatic int frame_len(input frame_t f);
    return 1 + clampn(f.nbits) + ((f.par == 1 || f.par == 2) ? 1 : 0) + (f.stop2 ? 2 : 1);
  endfunction

  // Expected line levels for every bit slot of a frame, slot 0 = start bit.
  function automatic logic [15:0] frame_bits(input frame_t f);
    logic [15:0] b;
    logic p;
    int nb;
    nb = clampn(f.nbits);
    b = '1;
    b[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      b[1+i] = f.data[i];
      p = p ^ f.data[i];
    end
    if (f.par == 1) b[1+nb] = p;
    else if (f.par == 2) b[1+nb] = ~p;
    return b;
  endfunction

  // Line monitor: pops the scoreboard at each start bit and checks every slot sample.
  frame_t      cur;
  logic [15:0] ebits;
  bit          mon_active = 1'b0;
  bit          bad;
  logic        got_bit;
  int          nb_m, bit_idx, samp, mdiv;
  int          gap = 0;
  int          frames_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      exp_q.delete();
      gap = 0;
    end else begin
      if (!mon_active && uart_tx === 1'b0) begin
        check("frame_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          if (cur.no_gap) check("frame_gap", gap, 0);
          ebits = frame_bits(cur);
          nb_m = frame_len(cur);
          mdiv = cur.div;
          bit_idx = 0; samp = 0; bad = 1'b0;
          mon_active = 1'b1;
        end
      end
      if (mon_active) begin
        if (!bad) got_bit = uart_tx;
        if (uart_tx !== ebits[bit_idx]) bad = 1'b1;
        samp++;
        if (samp == mdiv + 1) begin
          check($sformatf("f%0d_slot%0d", frames_done, bit_idx), got_bit, ebits[bit_idx]);
          samp = 0; bad = 1'b0;
          bit_idx++;
          if (bit_idx == nb_m) begin
            mon_active = 1'b0;
            gap = 0;
            frames_done++;
          end
        end
      end else if (uart_tx === 1'b1) begin
        gap++;
      end
    end
  end

  task automatic apply_cfg(input frame_t f);
    cfg_div = DIV_W'(f.div);
    cfg_nbits = 4'(f.nbits);
    cfg_parity = 2'(f.par);
    cfg_stop2 = f.stop2;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input frame_t f);
    int n;
    exp_q.push_back(f);
    s_data = f.data;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", s_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_busy || mon_active) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n < 5000), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int cnt, acc, maxl;
    logic [8:0] words[6];

    vecs[0].f = mk(9'h055,  8, 0, 0, 3, 0); vecs[0].exp_busy = 41;
    vecs[1].f = mk(9'h041,  7, 1, 0, 1, 0); vecs[1].exp_busy = 21;
    vecs[2].f = mk(9'h0FF,  8, 2, 1, 0, 0); vecs[2].exp_busy = 13;
    vecs[3].f = mk(9'h1F3,  9, 2, 0, 2, 0); vecs[3].exp_busy = 37;
    vecs[4].f = mk(9'h03A,  3, 3, 0, 0, 0); vecs[4].exp_busy = 8;
    vecs[5].f = mk(9'h155, 15, 1, 1, 1, 0); vecs[5].exp_busy = 27;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_fifo_level", fifo_level, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);

    // Single frames: latency, bit pattern and busy duration
    foreach (vecs[i]) begin
      apply_cfg(vecs[i].f);
      push_word(vecs[i].f);
      exp_frames++;
      check($sformatf("v%0d_lat_pre", i), uart_tx, 1);
      cnt = 0;
      while (tx_busy && cnt < 2000) begin
        if (cnt == 1) check($sformatf("v%0d_lat_start", i), uart_tx, 0);
        cnt++;
        @(negedge clk);
      end
      check($sformatf("v%0d_busy_cycles", i), cnt, vecs[i].exp_busy);
      check($sformatf("v%0d_pending", i), exp_q.size(), 0);
    end

    // 8O2 back-to-back frames with no idle gap
    apply_cfg(mk(9'h0, 8, 2, 1, 0, 0));
    push_word(mk(9'h0FF, 8, 2, 1, 0, 0));
    push_word(mk(9'h000, 8, 2, 1, 0, 1));
    exp_frames += 2;
    wait_idle();

    // FIFO fill: s_valid held high with 0x01..0x06
    apply_cfg(mk(9'h0, 8, 0, 0, 3, 0));
    for (int i = 0; i < 6; i++) words[i] = 9'(i + 1);
    acc = 0;
    maxl = 0;
    for (int c = 0; c < 12; c++) begin
      s_data = words[acc];
      s_valid = 1'b1;
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      if (s_ready) begin
        exp_q.push_back(mk(words[acc], 8, 0, 0, 3, (acc > 0)));
        acc++;
      end
      @(negedge clk);
    end
    check("fill_level_now", fifo_level, FIFO_DEPTH);
    check("fill_ready_low", s_ready, 0);
    s_valid = 1'b0;
    check("fill_accepted", acc, 5);
    check("fill_max_level", maxl, 4);
    exp_frames += acc;
    wait_idle();
    check("fill_drained_level", fifo_level, 0);

    // Mid-frame nbits change affects only the following frame
    apply_cfg(mk(9'h0, 8, 0, 0, 1, 0));
    push_word(mk(9'h0C3, 8, 0, 0, 1, 0));
    push_word(mk(9'h01B, 5, 0, 0, 1, 1));
    exp_frames += 2;
    repeat (6) @(negedge clk);
    cfg_nbits = 4'd5;
    wait_idle();

    // Reset during DATA, then recovery
    apply_cfg(mk(9'h0, 8, 0, 0, 3, 0));
    push_word(mk(9'h0A5, 8, 0, 0, 3, 0));
    push_word(mk(9'h03C, 8, 0, 0, 3, 1));
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_uart_tx", uart_tx, 1);
    check("midrst_fifo_level", fifo_level, 0);
    check("midrst_tx_busy", tx_busy, 0);
    check("midrst_s_ready", s_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_word(mk(9'h0A5, 8, 0, 0, 3, 0));
    exp_frames++;
    wait_idle();

    check("frames_done", frames_done, exp_frames);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
